// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one imem read per PC, held in IR for decode.
// Optional FETCH_TIMEOUT_EN adds an 8-bit ack watchdog that forces FAULT.
module fetch_unit #(
    parameter logic [31:0] RESET_IR = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [3:0]  PC4,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        PCWre,
    output logic [15:0] Immediate,
    output logic [31:0] JumpPC,
    output logic        fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DROP  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_req, w_req_next;
    logic [31:0] r_addr, w_addr_next;
    logic [31:0] r_ir, w_ir_next;
    logic [31:0] r_ir_pc, w_ir_pc_next;
    logic        r_valid, w_valid_next;
    logic        r_pcwre, w_pcwre_next;
    logic        r_fault, w_fault_next;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  r_cnt, w_cnt_next;
`endif

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_addr_next  = r_addr;
        w_ir_next    = r_ir;
        w_ir_pc_next = r_ir_pc;
        w_valid_next = r_valid;
        w_pcwre_next = 1'b0;
        w_fault_next = r_fault;
`ifdef FETCH_TIMEOUT_EN
        w_cnt_next   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (Address[1:0] != 2'b00) begin
                    w_state_next = FAULT;
                    w_fault_next = 1'b1;
                end else begin
                    w_addr_next  = Address;
                    w_req_next   = 1'b1;
                    w_state_next = REQ;
`ifdef FETCH_TIMEOUT_EN
                    w_cnt_next   = 8'd0;
`endif
                end
            end
            REQ: begin
                if (flush) begin
                    if (imem_ack) begin
                        w_req_next   = 1'b0;
                        w_state_next = IDLE;
                    end else begin
                        // The bus cannot be cancelled, so the stale ack is absorbed in DROP.
                        w_state_next = DROP;
`ifdef FETCH_TIMEOUT_EN
                        w_cnt_next   = 8'd0;
`endif
                    end
                end else if (imem_ack) begin
                    w_ir_next    = imem_rdata;
                    w_ir_pc_next = r_addr;
                    w_req_next   = 1'b0;
                    w_valid_next = 1'b1;
                    w_pcwre_next = 1'b1;
                    w_state_next = HOLD;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (r_cnt == TIMEOUT_LAST) begin
                        w_state_next = FAULT;
                        w_fault_next = 1'b1;
                        w_req_next   = 1'b0;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
`endif
                end
            end
            DROP: begin
                if (imem_ack) begin
                    w_req_next   = 1'b0;
                    w_state_next = IDLE;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (r_cnt == TIMEOUT_LAST) begin
                        w_state_next = FAULT;
                        w_fault_next = 1'b1;
                        w_req_next   = 1'b0;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
`endif
                end
            end
            HOLD: begin
                if (flush || ir_ready) begin
                    w_valid_next = 1'b0;
                    w_state_next = IDLE;
                end
            end
            FAULT: begin
                w_fault_next = 1'b1;
                w_req_next   = 1'b0;
                w_valid_next = 1'b0;
            end
            default: begin
                w_state_next = IDLE;
                w_req_next   = 1'b0;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= 32'h0;
            r_ir    <= RESET_IR;
            r_ir_pc <= 32'h0;
            r_valid <= 1'b0;
            r_pcwre <= 1'b0;
            r_fault <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
        end else begin
            r_state <= w_state_next;
            r_req   <= w_req_next;
            r_addr  <= w_addr_next;
            r_ir    <= w_ir_next;
            r_ir_pc <= w_ir_pc_next;
            r_valid <= w_valid_next;
            r_pcwre <= w_pcwre_next;
            r_fault <= w_fault_next;
`ifdef FETCH_TIMEOUT_EN
            r_cnt   <= w_cnt_next;
`endif
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign IR        = r_ir;
    assign ir_pc     = r_ir_pc;
    assign ir_valid  = r_valid;
    assign PCWre     = r_pcwre;
    assign fault     = r_fault;
    assign Immediate = r_ir[15:0];
    assign JumpPC    = {PC4, r_ir[25:0], 2'b00};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetches plus hand-written
// flush, misalignment, reset and (with FETCH_TIMEOUT_EN) timeout sequences.
module tb_fetch_unit;

    localparam logic [31:0] RST_IR = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [3:0]  PC4 = 4'h0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] IR;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        PCWre;
    logic [15:0] Immediate;
    logic [31:0] JumpPC;
    logic        fault;

    fetch_unit #(.RESET_IR(RST_IR), .TIMEOUT(4)) dut (
        .CLK(CLK), .Reset(Reset), .Address(Address), .PC4(PC4), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .IR(IR), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .PCWre(PCWre), .Immediate(Immediate),
        .JumpPC(JumpPC), .fault(fault)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int pcwre_cnt = 0;

    always @(negedge CLK) if (Reset && PCWre) pcwre_cnt++;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        int          stall;
        logic [3:0]  pc4;
        logic [15:0] exp_imm;
        logic [31:0] exp_jump;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called in the first HOLD cycle: pops the scoreboard and compares IR/ir_pc.
    task automatic check_hold_entry(input string tag);
        sb_t e;
        chk({tag, " ir_valid"}, 32'(ir_valid), 32'd1);
        chk({tag, " PCWre"}, 32'(PCWre), 32'd1);
        chk({tag, " imem_req"}, 32'(imem_req), 32'd0);
        n_chk++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " IR"}, IR, e.data);
            chk({tag, " ir_pc"}, ir_pc, e.pc);
        end
    endtask

    task automatic do_fetch(input int idx, input vec_t v);
        string tag;
        int    p0;
        tag = $sformatf("vec%0d", idx);
        p0 = pcwre_cnt;
        Address = v.addr;
        PC4 = v.pc4;
        imem_ack = 1'b0;
        ir_ready = 1'b0;
        tick();
        chk({tag, " req"}, 32'(imem_req), 32'd1);
        chk({tag, " imem_addr"}, imem_addr, v.addr);
        for (int i = 0; i < v.waits; i++) begin
            Address = v.addr + 32'h100;
            tick();
            chk({tag, " wait req"}, 32'(imem_req), 32'd1);
            chk({tag, " wait addr"}, imem_addr, v.addr);
            chk({tag, " wait valid"}, 32'(ir_valid), 32'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = v.data;
        sb_q.push_back('{data: v.data, pc: v.addr});
        tick();
        imem_ack = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        check_hold_entry(tag);
        chk({tag, " Immediate"}, 32'(Immediate), 32'(v.exp_imm));
        chk({tag, " JumpPC"}, JumpPC, v.exp_jump);
        for (int i = 0; i < v.stall; i++) begin
            tick();
            chk({tag, " stall valid"}, 32'(ir_valid), 32'd1);
            chk({tag, " stall IR"}, IR, v.data);
            chk({tag, " stall req"}, 32'(imem_req), 32'd0);
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk({tag, " consumed"}, 32'(ir_valid), 32'd0);
        chk({tag, " PCWre count"}, 32'(pcwre_cnt - p0), 32'd1);
        $display("txn %s addr=%h IR=%h waits=%0d stall=%0d", tag, v.addr, IR, v.waits, v.stall);
    endtask

    initial begin
        int p0;
        vecs[0] = '{32'h0000_0000, 32'h0800_0004, 0, 0, 4'h0, 16'h0004, 32'h0000_0010};
        vecs[1] = '{32'h0000_0004, 32'h0C00_0040, 3, 0, 4'h0, 16'h0040, 32'h0000_0100};
        vecs[2] = '{32'h0000_0008, 32'h8C22_FFFC, 1, 4, 4'h4, 16'hFFFC, 32'h408B_FFF0};
        vecs[3] = '{32'hF000_0010, 32'h0BFF_FFFF, 2, 1, 4'hF, 16'hFFFF, 32'hFFFF_FFFC};

        // Reset state
        tick();
        tick();
        chk("rst IR", IR, RST_IR);
        chk("rst ir_pc", ir_pc, 32'h0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst req", 32'(imem_req), 32'd0);
        chk("rst valid", 32'(ir_valid), 32'd0);
        chk("rst PCWre", 32'(PCWre), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        $display("txn reset IR=%h", IR);
        Reset = 1'b1;

        for (int i = 0; i < 4; i++) do_fetch(i, vecs[i]);

        // Flush in REQ with no ack; late ack carries junk that must be discarded
        p0 = pcwre_cnt;
        Address = 32'h0000_0020;
        tick();
        chk("flushA req", 32'(imem_req), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushA drop req", 32'(imem_req), 32'd1);
        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("flushA req low", 32'(imem_req), 32'd0);
        chk("flushA IR", IR, 32'h0BFF_FFFF);
        chk("flushA valid", 32'(ir_valid), 32'd0);
        chk("flushA PCWre count", 32'(pcwre_cnt - p0), 32'd0);
        $display("txn flush-no-ack IR=%h", IR);

        // Flush coinciding with ack in REQ
        tick();
        flush = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        tick();
        flush = 1'b0;
        imem_ack = 1'b0;
        chk("flushB IR", IR, 32'h0BFF_FFFF);
        chk("flushB valid", 32'(ir_valid), 32'd0);
        chk("flushB req", 32'(imem_req), 32'd0);
        chk("flushB PCWre count", 32'(pcwre_cnt - p0), 32'd0);
        $display("txn flush-with-ack IR=%h", IR);

        // Flush in HOLD wins over ir_ready=0 and keeps the registered PCWre
        Address = 32'h0000_0030;
        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        sb_q.push_back('{data: 32'h1234_5678, pc: 32'h0000_0030});
        tick();
        imem_ack = 1'b0;
        check_hold_entry("flushC");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushC valid", 32'(ir_valid), 32'd0);
        chk("flushC PCWre count", 32'(pcwre_cnt - p0), 32'd1);
        $display("txn flush-in-hold IR=%h", IR);

        // Misalignment
        Address = 32'h0000_0002;
        tick();
        chk("mis fault", 32'(fault), 32'd1);
        chk("mis req", 32'(imem_req), 32'd0);
        Address = 32'h0000_0040;
        tick();
        tick();
        chk("mis sticky", 32'(fault), 32'd1);
        chk("mis req stays low", 32'(imem_req), 32'd0);
        #2 Reset = 1'b0;
        #1;
        chk("mis reset clears", 32'(fault), 32'd0);
        $display("txn misalign fault cleared=%0d", !fault);
        tick();
        Reset = 1'b1;

        // Asynchronous reset drops an in-flight request mid-cycle
        tick();
        chk("arst req", 32'(imem_req), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("arst req drop", 32'(imem_req), 32'd0);
        chk("arst IR", IR, RST_IR);
        $display("txn async-reset req=%0d", imem_req);
        tick();
        Reset = 1'b1;

`ifdef FETCH_TIMEOUT_EN
        tick();
        chk("tmo req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tmo waiting", 32'(fault), 32'd0);
        end
        tick();
        chk("tmo fault", 32'(fault), 32'd1);
        chk("tmo req low", 32'(imem_req), 32'd0);
        $display("txn timeout fault=%0d", fault);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly downstream of the program counter. It takes the current `Address`, reads one 32-bit word from instruction memory through a req/ack handshake, holds it in the instruction register, and offers it to decode through a valid/ready handshake. It produces the `PCWre` pulse that advances the PC. It also produces `Immediate` and `JumpPC`, which feed back into the PC's next-address logic.

## Interface
- `RESET_IR`, default 32'h0000_0000: IR value after reset.
- `TIMEOUT`, default 255: maximum cycles to wait for `imem_ack`; 8-bit counter, legal range 1..255.
- `CLK` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: reset, asynchronous, active-low.
- `Address` in 32: current PC.
- `PC4` in 4: `Address[31:28]` of the current PC.
- `flush` in 1: PC redirected; discard any in-flight or held word.
- `imem_req` out 1: read request; registered.
- `imem_addr` out 32: read address; registered, stable while `imem_req`=1.
- `imem_ack` in 1: read data valid this cycle.
- `imem_rdata` in 32: read data.
- `IR` out 32: instruction register.
- `ir_pc` out 32: address the word in `IR` was fetched from.
- `ir_valid` out 1: `IR` holds a word not yet consumed.
- `ir_ready` in 1: decode accepts `IR` this cycle.
- `PCWre` out 1: one-cycle PC-advance pulse.
- `Immediate` out 16: `IR[15:0]`, combinational.
- `JumpPC` out 32: `{PC4, IR[25:0], 2'b00}`, combinational.
- `fault` out 1: sticky fetch fault.

## Operation
**Reset values:** state IDLE; `IR`=`RESET_IR`; `ir_pc`, `imem_addr` and counter = 0; `imem_req`, `ir_valid`, `PCWre` and `fault` = 0.

**States:**
- IDLE
  - If `Address[1:0]`!=0, go to FAULT.
  - Otherwise register `imem_addr`=`Address` and `imem_req`=1, then go to REQ.
- REQ (`imem_req`=1)
  - `flush`=1 with `imem_ack`=1: drop the data, `imem_req`=0, go to IDLE.
  - `flush`=1 with no ack: go to DROP.
  - `imem_ack`=1: `IR`<=`imem_rdata`, `ir_pc`<=`imem_addr`, `imem_req`=0, `ir_valid`<=1, `PCWre`<=1, go to HOLD.
- DROP (`imem_req`=1, the bus is never cancelled): on `imem_ack`, discard the data, `imem_req`=0, go to IDLE.
- HOLD (`ir_valid`=1)
  - `flush`=1: `ir_valid`<=0, go to IDLE. `flush` has priority over `ir_ready`.
  - Otherwise `ir_ready`=1: `ir_valid`<=0, go to IDLE.
  - `IR` stays stable while waiting.
- FAULT: `fault`=1, `imem_req`=0, `ir_valid`=0; left only by reset.

**Rules:**
- `PCWre` is high for exactly the first cycle of each HOLD entry and never otherwise. `flush` does not suppress a `PCWre` that is already registered.
- `Immediate` and `JumpPC` track `IR` and `PC4` combinationally. `PC4` is sampled after the PC has advanced, giving (PC+4)[31:28] semantics.
- Reset mid-operation drops `imem_req` immediately, asynchronously. Instruction memory tolerates abandoned requests.

## Timing
- Zero-wait memory (ack in the first REQ cycle): IDLE→REQ→HOLD, so `ir_valid` rises 2 cycles after IDLE.
- The issue rate is at best one instruction per 3 cycles (IDLE, REQ, HOLD).
- N wait cycles add N cycles to the REQ dwell.
- `PCWre` is high in the first HOLD cycle. The PC updates on the falling edge inside that cycle, so the new `Address` is sampled in the next IDLE.
- `imem_ack` is ignored outside REQ and DROP.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ or DROP and increments every cycle without ack.
  - Reaching `TIMEOUT` forces FAULT and drops `imem_req`.
- `FETCH_TIMEOUT_EN` undefined:
  - There is no counter; REQ and DROP wait indefinitely.
  - Only misalignment causes FAULT.

## Test plan
- **Basic fetch:** reset, then `Address`=0x0000_0000, zero-wait memory returns 0x0800_0004, `ir_ready`=1 → `ir_valid` in cycle 2, `IR`=0x0800_0004, `ir_pc`=0, `PCWre` one cycle, `Immediate`=0x0004, `JumpPC`=0x0000_0010.
- **Wait states:** ack delayed 3 cycles → `imem_addr` stable throughout; `ir_valid` rises in cycle 5; exactly one `PCWre`.
- **Backpressure:** `ir_ready`=0 for 4 cycles in HOLD → `IR` stable, no new `imem_req`, `PCWre` only once.
- **Flush with no ack:** `flush` in REQ with no ack, ack arrives 2 cycles later with 0xDEAD_BEEF → `IR` unchanged, no `ir_valid`, no `PCWre`, returns to IDLE.
- **Misalignment:** `Address`=0x0000_0002 → `fault`=1, `imem_req` never asserted; `Reset`=0 clears it.
- **Timeout (`FETCH_TIMEOUT_EN`, `TIMEOUT`=4):** no ack → `fault`=1 after 4 REQ cycles, `imem_req`=0.
